debug_cmd_parser: RTL and testbench
===================================

# debug_cmd_parser

Byte-stream command deframer for the debug path. It consumes the one-clock `rx_done`/`d_out` byte strobes from the UART receiver and hunts for a sync byte. It then assembles a fixed 8-byte frame (sync, opcode, address, 4 data bytes, checksum) and presents a validated command to the debug unit through a valid/ready handshake. It also flags checksum errors, inter-byte timeouts and bytes dropped while a command is pending.

## Interface
Parameters:
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `TIMEOUT_TICKS`, 16'd1600, maximum `s_tick` count between bytes inside a frame. At 16x oversampling this is 10 byte times.

Ports:
- `clock`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-high.
- `s_tick`  in  1  baud oversampling tick, shared with the UART receiver.
- `rx_done`  in  1  one-clock pulse: `rx_data` holds a new byte.
- `rx_data`  in  8  received byte.
- `cmd_ready`  in  1  debug unit accepts the command.
- `cmd_valid`  out  1  command fields valid; held until accepted.
- `cmd_op`  out  8  opcode.
- `cmd_addr`  out  8  address.
- `cmd_data`  out  32  data, little-endian (first data byte = [7:0]).
- `chk_err`  out  1  one-clock pulse: checksum mismatch.
- `timeout_err`  out  1  one-clock pulse: frame abandoned on timeout.
- `overrun_err`  out  1  one-clock pulse: byte dropped while `cmd_valid` pending.

## Operation
- States: HUNT, OP, ADDR, DATA, CHK, HOLD. A byte is accepted on the clock edge where `rx_done`=1.
- HUNT: a byte equal to `SYNC_BYTE` goes to OP and clears the checksum. Any other byte is ignored silently.
- OP: latch the opcode into shadow, checksum ^= byte, go to ADDR.
- ADDR: latch the address into shadow, checksum ^= byte, go to DATA with the byte index cleared to 0.
- DATA: store the byte at shadow[8*idx +: 8], checksum ^= byte, increment idx. After idx 3 is stored, go to CHK.
- CHK: byte == running checksum: copy shadow into `cmd_op`/`cmd_addr`/`cmd_data`, set `cmd_valid`, go to HOLD. Mismatch: pulse `chk_err`, go to HUNT, outputs unchanged.
- Checksum = XOR of opcode, address and the 4 data bytes. The sync byte is excluded.
- HOLD: `cmd_valid`=1 and fields stable.
  - `cmd_ready`=1: clear `cmd_valid` and go to HUNT.
  - `rx_done`=1 without `cmd_ready`: pulse `overrun_err` and discard the byte.
- Timeout counter (16 bit):
  - Active only in OP, ADDR, DATA and CHK.
  - Cleared on every accepted byte and on entry to OP.
  - Increments on `s_tick`.
  - On reaching `TIMEOUT_TICKS`: pulse `timeout_err`, go to HUNT. The counter saturates and does not wrap.
- A sync byte received mid-frame is treated as data. No resynchronisation occurs except via checksum error or timeout.

## Timing
- Reset values:
  - `cmd_valid`, `chk_err`, `timeout_err`, `overrun_err` = 0.
  - `cmd_op`, `cmd_addr` = 0; `cmd_data` = 0.
  - State HUNT, counter 0.
- Latency: `cmd_valid` rises on the clock edge that accepts the checksum byte, 1 cycle after the `rx_done` sample. All outputs are registered.
- Error pulses last exactly 1 clock.
- Simultaneous events:
  - `rx_done` and timeout expiry in the same cycle: the byte wins, the counter is cleared, and there is no `timeout_err`.
  - HOLD with `cmd_ready` and `rx_done` in the same cycle: the handshake completes, and the byte is evaluated as in HUNT. If it equals `SYNC_BYTE`, the next state is OP. There is no `overrun_err`.
- `cmd_ready` while `cmd_valid`=0: ignored.
- Asynchronous reset mid-frame or in HOLD: return immediately to reset values. The partial frame is lost.

## Structure
- Shared package `debug_pkg`: state encoding localparams, `SYNC_BYTE` default, opcode constants used by the debug unit (read reg, write reg, step, run, halt).
- One natural sub-module, `tick_timeout`. It is a saturating counter with an `s_tick` enable, a clear input, a `TIMEOUT_TICKS` compare, and a single-cycle `expired` output.
- All other logic (FSM, shadow registers, checksum) lives in one module.

## Test plan
- Good frame A5 01 10 78 56 34 12 19 -> `cmd_valid`=1, `cmd_op`=01, `cmd_addr`=10, `cmd_data`=32'h12345678. Hold `cmd_ready`=0 for 5 clocks: fields stable. Assert `cmd_ready` -> `cmd_valid`=0 the next cycle.
- Same frame with checksum 18 -> `chk_err` 1-clock pulse, `cmd_valid` stays 0, outputs keep their previous values. A following good frame is accepted.
- Garbage 00 FF 3C, then the good frame -> garbage ignored, command decoded correctly.
- A5 01 10, then silence for 1600 `s_tick` -> `timeout_err` pulse, state HUNT. Stray byte 78 is then ignored.
- Good frame, `cmd_ready`=0, extra byte 55 -> `overrun_err` pulse, fields unchanged. Then `cmd_ready` and `rx_done` with A5 in the same cycle -> handshake completes, no `overrun_err`, parser in OP.
- Reset asserted after A5 01 10 78 -> all outputs 0 immediately. A fresh frame decodes correctly.

Source files
------------

// File: rtl/debug_pkg.sv
// debug_pkg
// Shared definitions for the debug command path: parser state encoding,
// default frame marker and inter-byte timeout, and the opcode values the
// debug unit understands.
package debug_pkg;

  localparam logic [7:0]  DEFAULT_SYNC_BYTE     = 8'hA5;
  localparam logic [15:0] DEFAULT_TIMEOUT_TICKS = 16'd1600;
  localparam int          CMD_DATA_W            = 32;

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_OP   = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_HOLD = 3'd5
  } state_t;

  localparam logic [7:0] OP_READ_REG  = 8'h01;
  localparam logic [7:0] OP_WRITE_REG = 8'h02;
  localparam logic [7:0] OP_STEP      = 8'h03;
  localparam logic [7:0] OP_RUN       = 8'h04;
  localparam logic [7:0] OP_HALT      = 8'h05;

endpackage

// File: rtl/debug_cmd_parser_if.sv
// debug_cmd_parser_if
// Valid/ready command channel from the frame parser to the debug unit.
//   cmd_valid : command fields valid, held until accepted
//   cmd_ready : debug unit accepts the command
//   cmd_op    : opcode
//   cmd_addr  : register address
//   cmd_data  : 32-bit payload, little-endian byte order on the wire
// master = parser side, slave = debug unit side.
interface debug_cmd_parser_if;
  import debug_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [7:0]            cmd_op;
  logic [7:0]            cmd_addr;
  logic [CMD_DATA_W-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_addr,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_addr,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/tick_timeout.sv
// tick_timeout
// Saturating inter-byte timer. Counts i_tick pulses while enabled and raises
// o_expired for a single cycle once the count reaches TIMEOUT_TICKS.
//   clock, reset : system clock, async active-high reset
//   i_enable     : timer active; when low the count is held at zero
//   i_clear      : synchronous clear (an accepted byte)
//   i_tick       : oversampling tick, count enable
//   o_expired    : one-cycle pulse at terminal count
module tick_timeout
  import debug_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS
) (
  input  logic clock,
  input  logic reset,
  input  logic i_enable,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expired
);

  logic [15:0] r_count;
  logic        r_fired;
  logic        w_at_limit;

  assign w_at_limit = (r_count == TIMEOUT_TICKS);
  // r_fired keeps the pulse to one cycle even if the count sits saturated.
  assign o_expired  = i_enable && w_at_limit && !r_fired;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_fired <= 1'b0;
    end else if (!i_enable || i_clear) begin
      r_count <= '0;
      r_fired <= 1'b0;
    end else begin
      if (i_tick && !w_at_limit)
        r_count <= r_count + 16'd1;
      if (o_expired)
        r_fired <= 1'b1;
    end
  end

endmodule

// File: rtl/debug_cmd_parser.sv
// debug_cmd_parser
// Deframes the UART byte stream into debug commands. Frame layout:
//   SYNC, OP, ADDR, D0, D1, D2, D3, CHK   (CHK = XOR of OP..D3)
// Ports:
//   clock, reset  : system clock, async active-high reset
//   i_s_tick      : baud oversampling tick (inter-byte timeout base)
//   i_rx_done     : one-clock strobe, i_rx_data holds a new byte
//   i_rx_data     : received byte
//   cmd           : valid/ready command channel (master side)
//   o_chk_err     : one-clock pulse, checksum mismatch
//   o_timeout_err : one-clock pulse, frame abandoned on inter-byte timeout
//   o_overrun_err : one-clock pulse, byte dropped while a command is pending
//
// state | meaning
// HUNT  | waiting for the sync byte, other bytes ignored
// OP    | expecting opcode
// ADDR  | expecting address
// DATA  | expecting data byte r_idx (0..3)
// CHK   | expecting checksum byte
// HOLD  | command presented, waiting for cmd_ready
module debug_cmd_parser
  import debug_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE     = DEFAULT_SYNC_BYTE,
  parameter logic [15:0] TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_s_tick,
  input  logic               i_rx_done,
  input  logic [7:0]         i_rx_data,
  debug_cmd_parser_if.master cmd,
  output logic               o_chk_err,
  output logic               o_timeout_err,
  output logic               o_overrun_err
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_chk;
  logic [1:0]            r_idx;
  logic [7:0]            r_op_sh;
  logic [7:0]            r_addr_sh;
  logic [CMD_DATA_W-1:0] r_data_sh;
  logic                  r_cmd_valid;
  logic [7:0]            r_cmd_op;
  logic [7:0]            r_cmd_addr;
  logic [CMD_DATA_W-1:0] r_cmd_data;
  logic                  r_chk_err;
  logic                  r_timeout_err;
  logic                  r_overrun_err;

  logic w_chk_err;
  logic w_timeout_err;
  logic w_overrun_err;
  logic w_load_cmd;
  logic w_timer_en;
  logic w_expired;
  logic w_is_sync;

  assign w_is_sync  = (i_rx_data == SYNC_BYTE);
  assign w_timer_en = (r_state == ST_OP) || (r_state == ST_ADDR) ||
                      (r_state == ST_DATA) || (r_state == ST_CHK);

  // Every accepted byte restarts the timer; entry to OP is itself an
  // accepted byte and the timer is idle in HUNT, so that case is covered too.
  tick_timeout #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) u_tick_timeout (
    .clock     (clock),
    .reset     (reset),
    .i_enable  (w_timer_en),
    .i_clear   (i_rx_done),
    .i_tick    (i_s_tick),
    .o_expired (w_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_state <= ST_HUNT;
    else
      r_state <= w_state_nxt;
  end

  // A byte arriving in the same cycle as expiry wins over the timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_chk_err     = 1'b0;
    w_timeout_err = 1'b0;
    w_overrun_err = 1'b0;
    w_load_cmd    = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (i_rx_done && w_is_sync)
          w_state_nxt = ST_OP;
      end
      ST_OP: begin
        if (i_rx_done) begin
          w_state_nxt = ST_ADDR;
        end else if (w_expired) begin
          w_state_nxt   = ST_HUNT;
          w_timeout_err = 1'b1;
        end
      end
      ST_ADDR: begin
        if (i_rx_done) begin
          w_state_nxt = ST_DATA;
        end else if (w_expired) begin
          w_state_nxt   = ST_HUNT;
          w_timeout_err = 1'b1;
        end
      end
      ST_DATA: begin
        if (i_rx_done) begin
          if (r_idx == 2'd3)
            w_state_nxt = ST_CHK;
        end else if (w_expired) begin
          w_state_nxt   = ST_HUNT;
          w_timeout_err = 1'b1;
        end
      end
      ST_CHK: begin
        if (i_rx_done) begin
          if (i_rx_data == r_chk) begin
            w_state_nxt = ST_HOLD;
            w_load_cmd  = 1'b1;
          end else begin
            w_state_nxt = ST_HUNT;
            w_chk_err   = 1'b1;
          end
        end else if (w_expired) begin
          w_state_nxt   = ST_HUNT;
          w_timeout_err = 1'b1;
        end
      end
      ST_HOLD: begin
        // Handshake completing frees the parser, so a byte in the same
        // cycle is judged as if already back in HUNT.
        if (cmd.cmd_ready)
          w_state_nxt = (i_rx_done && w_is_sync) ? ST_OP : ST_HUNT;
        else if (i_rx_done)
          w_overrun_err = 1'b1;
      end
      default: w_state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_chk         <= '0;
      r_idx         <= '0;
      r_op_sh       <= '0;
      r_addr_sh     <= '0;
      r_data_sh     <= '0;
      r_cmd_valid   <= 1'b0;
      r_cmd_op      <= '0;
      r_cmd_addr    <= '0;
      r_cmd_data    <= '0;
      r_chk_err     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_chk_err     <= w_chk_err;
      r_timeout_err <= w_timeout_err;
      r_overrun_err <= w_overrun_err;
      r_cmd_valid   <= (w_state_nxt == ST_HOLD);
      if (w_load_cmd) begin
        r_cmd_op   <= r_op_sh;
        r_cmd_addr <= r_addr_sh;
        r_cmd_data <= r_data_sh;
      end
      if (i_rx_done) begin
        case (r_state)
          ST_HUNT, ST_HOLD: r_chk <= '0;
          ST_OP: begin
            r_op_sh <= i_rx_data;
            r_chk   <= r_chk ^ i_rx_data;
          end
          ST_ADDR: begin
            r_addr_sh <= i_rx_data;
            r_chk     <= r_chk ^ i_rx_data;
            r_idx     <= '0;
          end
          ST_DATA: begin
            r_data_sh[{r_idx, 3'b000} +: 8] <= i_rx_data;
            r_chk <= r_chk ^ i_rx_data;
            r_idx <= r_idx + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign cmd.cmd_valid = r_cmd_valid;
  assign cmd.cmd_op    = r_cmd_op;
  assign cmd.cmd_addr  = r_cmd_addr;
  assign cmd.cmd_data  = r_cmd_data;
  assign o_chk_err     = r_chk_err;
  assign o_timeout_err = r_timeout_err;
  assign o_overrun_err = r_overrun_err;

endmodule

// File: tb/tb_debug_cmd_parser.sv
// tb_debug_cmd_parser
// Directed bench for debug_cmd_parser. Inputs change on the falling edge,
// outputs are read on the falling edge after the accepting rising edge.
module tb_debug_cmd_parser;
  import debug_pkg::*;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic       s_tick  = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       chk_err;
  logic       timeout_err;
  logic       overrun_err;

  debug_cmd_parser_if cmd_if();

  int n_tests = 0;
  int n_fail  = 0;
  int chk_cnt  = 0;
  int tout_cnt = 0;
  int ovr_cnt  = 0;

  debug_cmd_parser #(
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_TICKS (16'd1600)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .i_s_tick      (s_tick),
    .i_rx_done     (rx_done),
    .i_rx_data     (rx_data),
    .cmd           (cmd_if),
    .o_chk_err     (chk_err),
    .o_timeout_err (timeout_err),
    .o_overrun_err (overrun_err)
  );

  always #10 clock = ~clock;

  // Pulse counters sampled mid high phase, clear of both edges.
  always @(posedge clock) begin
    #5;
    if (chk_err)     chk_cnt++;
    if (timeout_err) tout_cnt++;
    if (overrun_err) ovr_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clock);
    rx_done = 1'b0;
  endtask

  // Sends the first n bytes of f, most significant byte first.
  task automatic send_bytes(input logic [63:0] f, input int n);
    for (int i = 0; i < n; i++)
      send_byte(f[63-8*i -: 8]);
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_tests++;
    if ({cmd_if.cmd_valid, chk_err, timeout_err, overrun_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000",
               {cmd_if.cmd_valid, chk_err, timeout_err, overrun_err});
    end
    n_tests++;
    if ({cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_fields: got %h expected 0",
               {cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data});
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_good_frame();
    send_bytes(64'hA5_01_10_78_56_34_12_19, 7);
    n_tests++;
    if (cmd_if.cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL good_valid_early: got %b expected 0", cmd_if.cmd_valid);
    end
    send_byte(8'h19);
    n_tests++;
    if ({cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data} !== {1'b1, 48'h01_10_12345678}) begin
      n_fail++;
      $display("FAIL good_cmd: got %b %h %h %h expected 1 01 10 12345678",
               cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_tests++;
      if ({cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data} !== {1'b1, 48'h01_10_12345678}) begin
        n_fail++;
        $display("FAIL good_hold_%0d: got %b %h %h %h expected 1 01 10 12345678",
                 i, cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data);
      end
    end
    cmd_if.cmd_ready = 1'b1;
    @(negedge clock);
    cmd_if.cmd_ready = 1'b0;
    n_tests++;
    if (cmd_if.cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL good_accept: got valid %b expected 0", cmd_if.cmd_valid);
    end
  endtask

  task automatic test_chk_err();
    int c0;
    c0 = chk_cnt;
    send_bytes(64'hA5_01_10_78_56_34_12_18, 8);
    n_tests++;
    if ({chk_err, cmd_if.cmd_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL chk_pulse: got chk_err,valid %b expected 10", {chk_err, cmd_if.cmd_valid});
    end
    @(negedge clock);
    n_tests++;
    if (chk_err !== 1'b0 || chk_cnt != c0 + 1) begin
      n_fail++;
      $display("FAIL chk_width: got chk_err %b count %0d expected 0 and %0d", chk_err, chk_cnt - c0, 1);
    end
    // Different fields, bad checksum: presented fields must keep the old command.
    send_bytes(64'hA5_02_20_11_22_33_44_00, 8);
    n_tests++;
    if ({cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data} !== {1'b0, 48'h01_10_12345678}) begin
      n_fail++;
      $display("FAIL chk_fields_kept: got %b %h %h %h expected 0 01 10 12345678",
               cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data);
    end
    send_bytes(64'hA5_03_20_11_22_33_44_67, 8);
    n_tests++;
    if ({cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data} !== {1'b1, 48'h03_20_44332211}) begin
      n_fail++;
      $display("FAIL chk_recover: got %b %h %h %h expected 1 03 20 44332211",
               cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data);
    end
    cmd_if.cmd_ready = 1'b1;
    @(negedge clock);
    cmd_if.cmd_ready = 1'b0;
  endtask

  task automatic test_garbage();
    int c0;
    c0 = chk_cnt + tout_cnt + ovr_cnt;
    send_bytes(64'h00_FF_3C_00_00_00_00_00, 3);
    n_tests++;
    if (cmd_if.cmd_valid !== 1'b0 || chk_cnt + tout_cnt + ovr_cnt != c0) begin
      n_fail++;
      $display("FAIL garbage_silent: got valid %b errors %0d expected 0 0",
               cmd_if.cmd_valid, chk_cnt + tout_cnt + ovr_cnt - c0);
    end
    send_bytes(64'hA5_05_7F_DE_AD_BE_EF_58, 8);
    n_tests++;
    if ({cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data} !== {1'b1, 48'h05_7F_EFBEADDE}) begin
      n_fail++;
      $display("FAIL garbage_frame: got %b %h %h %h expected 1 05 7f efbeadde",
               cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data);
    end
    cmd_if.cmd_ready = 1'b1;
    @(negedge clock);
    cmd_if.cmd_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int k;
    int c0;
    send_bytes(64'hA5_01_10_00_00_00_00_00, 3);
    s_tick = 1'b1;
    k = 0;
    while (k <= 2000) begin
      @(negedge clock);
      k++;
      if (timeout_err) break;
    end
    s_tick = 1'b0;
    n_tests++;
    if (k != 1601) begin
      n_fail++;
      $display("FAIL timeout_cycle: got pulse at tick cycle %0d expected 1601", k);
    end
    @(negedge clock);
    n_tests++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_width: got %b expected 0", timeout_err);
    end
    // Rest of the abandoned frame must be ignored in HUNT.
    c0 = chk_cnt;
    send_bytes(64'h78_56_34_12_19_00_00_00, 5);
    n_tests++;
    if (cmd_if.cmd_valid !== 1'b0 || chk_cnt != c0) begin
      n_fail++;
      $display("FAIL timeout_stray: got valid %b chk_errs %0d expected 0 0",
               cmd_if.cmd_valid, chk_cnt - c0);
    end
  endtask

  task automatic test_timeout_race();
    int t0;
    t0 = tout_cnt;
    send_byte(8'hA5);
    s_tick = 1'b1;
    repeat (1600) @(negedge clock);
    s_tick  = 1'b0;
    rx_done = 1'b1;
    rx_data = 8'h01;
    @(negedge clock);
    rx_done = 1'b0;
    send_bytes(64'h10_78_56_34_12_19_00_00, 6);
    n_tests++;
    if ({cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_data} !== {1'b1, 40'h01_12345678} || tout_cnt != t0) begin
      n_fail++;
      $display("FAIL timeout_race: got valid %b op %h data %h timeouts %0d expected 1 01 12345678 0",
               cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_data, tout_cnt - t0);
    end
    cmd_if.cmd_ready = 1'b1;
    @(negedge clock);
    cmd_if.cmd_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int o0;
    send_bytes(64'hA5_01_10_78_56_34_12_19, 8);
    o0 = ovr_cnt;
    send_byte(8'h55);
    n_tests++;
    if ({overrun_err, cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data} !== {2'b11, 48'h01_10_12345678}) begin
      n_fail++;
      $display("FAIL overrun_pulse: got %b %b %h %h %h expected 1 1 01 10 12345678",
               overrun_err, cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data);
    end
    @(negedge clock);
    n_tests++;
    if (overrun_err !== 1'b0 || ovr_cnt != o0 + 1) begin
      n_fail++;
      $display("FAIL overrun_width: got %b count %0d expected 0 and 1", overrun_err, ovr_cnt - o0);
    end
    cmd_if.cmd_ready = 1'b1;
    rx_done = 1'b1;
    rx_data = 8'hA5;
    @(negedge clock);
    cmd_if.cmd_ready = 1'b0;
    rx_done = 1'b0;
    n_tests++;
    if (cmd_if.cmd_valid !== 1'b0 || ovr_cnt != o0 + 1) begin
      n_fail++;
      $display("FAIL b2b_handshake: got valid %b overruns %0d expected 0 1", cmd_if.cmd_valid, ovr_cnt - o0);
    end
    // No further sync byte: the parser must already be in OP.
    send_bytes(64'h02_20_11_22_33_44_66_00, 7);
    n_tests++;
    if ({cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data} !== {1'b1, 48'h02_20_44332211}) begin
      n_fail++;
      $display("FAIL b2b_in_op: got %b %h %h %h expected 1 02 20 44332211",
               cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data);
    end
    cmd_if.cmd_ready = 1'b1;
    @(negedge clock);
    cmd_if.cmd_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    send_bytes(64'hA5_01_10_78_00_00_00_00, 4);
    #3 reset = 1'b1;
    #1;
    n_tests++;
    if ({cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data} !== 49'h0) begin
      n_fail++;
      $display("FAIL async_reset: got %b %h %h %h expected 0 00 00 00000000",
               cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data);
    end
    @(negedge clock);
    reset = 1'b0;
    send_bytes(64'hA5_05_7F_DE_AD_BE_EF_58, 8);
    n_tests++;
    if ({cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data} !== {1'b1, 48'h05_7F_EFBEADDE}) begin
      n_fail++;
      $display("FAIL reset_fresh: got %b %h %h %h expected 1 05 7f efbeadde",
               cmd_if.cmd_valid, cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data);
    end
    cmd_if.cmd_ready = 1'b1;
    @(negedge clock);
    cmd_if.cmd_ready = 1'b0;
  endtask

  initial begin
    cmd_if.cmd_ready = 1'b0;
    test_reset();
    test_good_frame();
    test_chk_err();
    test_garbage();
    test_timeout();
    test_timeout_race();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
